axis_chk_syn: RTL

AXIS_CHK_SYN -- requirements
Module: axis_chk_syn

---
 rtl/axis_syn_pkg.sv | 29 ++
 rtl/axis_lfsr16.sv | 25 ++
 rtl/axis_chk_syn.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/axis_syn_pkg.sv
// Shared definitions for the AXI-Stream sync/sequence checker and its stimulus generators.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package axis_syn_pkg;

    // Checker FSM: hunting for a header beat, or tracking a locked stream.
    typedef enum logic {
        SYNC = 1'b0,
        RUN  = 1'b1
    } chk_state_t;

    // Fixed header byte carried in tdata[31:24] of every beat.
    localparam logic [7:0]  HDR_BYTE  = 8'hAA;

    // Non-zero seed so the backpressure LFSR can never stall in the all-zero state.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // Bit positions inside err_type.
    localparam int ERR_DATA = 0;
    localparam int ERR_LAST = 1;
    localparam int ERR_DEST = 2;
    localparam int ERR_KEEP = 3;

    // Low 32 bits of a stream word for a given frame number (hi) and beat index (lo).
    function automatic logic [31:0] exp_word(input logic [7:0] hi, input logic [7:0] lo);
        return {HDR_BYTE, hi, 8'h00, lo};
    endfunction

endpackage

// File: rtl/axis_lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11), shifts left with feedback into bit 0.
// Latency: state advances one step per enabled cycle; rst reloads seed.
// Backpressure: none; free-running while en is high.
// Ports: clk, rst (sync, active-high), en (advance), seed (reset value), state (current value).
module axis_lfsr16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] seed,
    output logic [15:0] state
);

    logic feedback;

    assign feedback = state[15] ^ state[13] ^ state[12] ^ state[10];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= seed;
        end else if (en) begin
            state <= {state[14:0], feedback};
        end
    end

endmodule

// File: rtl/axis_chk_syn.sv
// AXI-Stream sink that locks onto a counting test stream and tallies frames and per-beat errors.
// Latency: status (locked, counters, flags) updates one cycle after the accepted beat.
// Backpressure: tready is registered; always 1 after reset, or LFSR-driven when AXIS_CHK_BP_EN is defined.
// Ports: clk, rst (sync, active-high); S_AXIS_* slave stream; clr_err clears err_cnt/err_type;
//        locked, frame_cnt, err_cnt (saturating), err_type {keep,dest,last,data} are status outputs.
module axis_chk_syn
    import axis_syn_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FRAME_LEN  = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   S_AXIS_tdata,
    input  logic [3:0]              S_AXIS_tdest,
    input  logic [DATA_WIDTH/8-1:0] S_AXIS_tkeep,
    input  logic                    S_AXIS_tlast,
    input  logic                    S_AXIS_tvalid,
    output logic                    S_AXIS_tready,
    input  logic                    clr_err,
    output logic                    locked,
    output logic [15:0]             frame_cnt,
    output logic [15:0]             err_cnt,
    output logic [3:0]              err_type
);

    if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 32) begin : g_bad_width
        $fatal(1, "axis_chk_syn: DATA_WIDTH must be a multiple of 8 and >= 32");
    end
    if (FRAME_LEN < 2 || FRAME_LEN > 256) begin : g_bad_len
        $fatal(1, "axis_chk_syn: FRAME_LEN must be in 2..256");
    end

    localparam logic [7:0] LAST_LO = 8'(FRAME_LEN - 1);

    chk_state_t            state;
    logic [7:0]            hi;
    logic [7:0]            lo;
    logic [3:0]            exp_dest;
    logic [1:0]            consec;
    logic [DATA_WIDTH-1:0] exp_data;
    logic [3:0]            err_vec;
    logic                  accept;
    logic                  sync_hit;
    logic                  beat_err;

    assign accept   = S_AXIS_tvalid & S_AXIS_tready;
    assign sync_hit = (S_AXIS_tdata[31:24] == HDR_BYTE) && (S_AXIS_tdata[15:0] == 16'h0000)
                      && (S_AXIS_tdest[3:1] == 3'b000);
    assign beat_err = accept && (state == RUN) && (|err_vec);

    always_comb begin
        exp_data       = '0;
        exp_data[31:0] = exp_word(hi, lo);
        err_vec           = '0;
        err_vec[ERR_DATA] = (S_AXIS_tdata != exp_data);
        err_vec[ERR_LAST] = (S_AXIS_tlast != (lo == LAST_LO));
        err_vec[ERR_DEST] = (S_AXIS_tdest != exp_dest);
        err_vec[ERR_KEEP] = (S_AXIS_tkeep != '1);
    end

    // Sink readiness.
`ifdef AXIS_CHK_BP_EN
    logic [15:0] lfsr_state;

    axis_lfsr16 u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .en    (1'b1),
        .seed  (LFSR_SEED),
        .state (lfsr_state)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            S_AXIS_tready <= 1'b0;
        end else begin
            S_AXIS_tready <= lfsr_state[0];
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            S_AXIS_tready <= 1'b0;
        end else begin
            S_AXIS_tready <= 1'b1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SYNC;
            locked    <= 1'b0;
            frame_cnt <= 16'h0000;
            err_cnt   <= 16'h0000;
            err_type  <= 4'h0;
            hi        <= 8'h00;
            lo        <= 8'h00;
            exp_dest  <= 4'h0;
            consec    <= 2'd0;
        end else begin
            // Clear has priority: an error landing on the clear cycle is dropped.
            if (clr_err) begin
                err_cnt  <= 16'h0000;
                err_type <= 4'h0;
            end else if (beat_err) begin
                err_type <= err_type | err_vec;
                if (err_cnt != 16'hFFFF) begin
                    err_cnt <= err_cnt + 16'd1;
                end
            end

            if (accept) begin
                case (state)
                    SYNC: begin
                        // The header beat is beat 0 of a frame, so tracking resumes at lo=1.
                        if (sync_hit) begin
                            hi       <= S_AXIS_tdata[23:16];
                            exp_dest <= S_AXIS_tdest;
                            lo       <= 8'd1;
                            consec   <= 2'd0;
                            state    <= RUN;
                            locked   <= 1'b1;
                        end
                    end
                    RUN: begin
                        // Frame boundaries follow the beat count, never the received tlast.
                        if (lo == LAST_LO) begin
                            lo          <= 8'd0;
                            hi          <= hi + 8'd1;
                            exp_dest[0] <= ~exp_dest[0];
                            frame_cnt   <= frame_cnt + 16'd1;
                        end else begin
                            lo <= lo + 8'd1;
                        end
                        // Lose lock after four counted error beats in a row. The run length
                        // ignores counter saturation so a saturated checker can still drop lock.
                        if (beat_err && !clr_err) begin
                            if (consec == 2'd3) begin
                                consec <= 2'd0;
                                state  <= SYNC;
                                locked <= 1'b0;
                            end else begin
                                consec <= consec + 2'd1;
                            end
                        end else begin
                            consec <= 2'd0;
                        end
                    end
                    default: begin
                        state  <= SYNC;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
